// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter sharing the single register-file read port between NREQ requesters.
// Drives the read-mux select and returns a registered word with $zero and write-back forwarding.
module rf_read_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [5*NREQ-1:0] req_addr,
  output logic [NREQ-1:0]   req_ready,
  output logic [4:0]        mux_sel,
  input  logic [31:0]       mux_rdata,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [31:0]       wr_data,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_data
);

  logic [IDW-1:0] r_rr_ptr;
  logic           r_rsp_valid;
  logic [IDW-1:0] r_rsp_id;
  logic [31:0]    r_rsp_data;

  logic [4:0]     w_addr [NREQ];
  logic           w_grant_any;
  logic [IDW-1:0] w_grant_id;
  logic           w_grant;
  logic [IDW-1:0] w_next_ptr;
  logic [4:0]     w_sel;
  logic [31:0]    w_rd_word;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
    assign w_addr[gi] = req_addr[5*gi +: 5];
  end

  // Scan from r_rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin : p_arb
    logic [IDW:0]   scan;
    logic [IDW-1:0] idx;
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    scan        = '0;
    idx         = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NREQ)) scan = scan - (IDW+1)'(NREQ);
      idx = scan[IDW-1:0];
      if (!w_grant_any && req_valid[idx]) begin
        w_grant_any = 1'b1;
        w_grant_id  = idx;
      end
    end
  end

  // Reset suppresses the grant so nothing is consumed while rst is high.
  assign w_grant    = w_grant_any & ~rst;
  assign w_sel      = w_grant ? w_addr[w_grant_id] : 5'd0;
  assign w_next_ptr = (w_grant_id == IDW'(NREQ-1)) ? '0 : w_grant_id + IDW'(1);

  always_comb begin
    w_rd_word = mux_rdata;
    if (ZERO_R0 != 0 && w_sel == 5'd0)
      w_rd_word = 32'h0;
    else if (wr_en && wr_addr == w_sel)
      w_rd_word = wr_data;
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_rr_ptr    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= 32'h0;
    end else if (w_grant) begin
      r_rr_ptr    <= w_next_ptr;
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_grant_id;
      r_rsp_data  <= w_rd_word;
    end else begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign req_ready = w_grant ? (NREQ'(1) << w_grant_id) : '0;
  assign mux_sel   = w_sel;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed bench for rf_read_arbiter: reset, single read, round-robin order,
// partial contention, write-back forwarding, $zero and reset during a grant.
module tb_rf_read_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [5*NREQ-1:0] req_addr;
  logic [NREQ-1:0]   req_ready;
  logic [4:0]        mux_sel;
  logic [31:0]       mux_rdata;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [31:0]       wr_data;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_data;

  int errors = 0;
  int checks = 0;

  rf_read_arbiter #(.NREQ(NREQ), .IDW(IDW), .ZERO_R0(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .mux_sel   (mux_sel),
    .mux_rdata (mux_rdata),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file read mux model: each register holds 0x1000_0000 + its index.
  assign mux_rdata = 32'h1000_0000 + {27'h0, mux_sel};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addrs(input logic [4:0] a3, input logic [4:0] a2,
                           input logic [4:0] a1, input logic [4:0] a0);
    req_addr = {a3, a2, a1, a0};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    set_addrs(5'd4, 5'd3, 5'd2, 5'd1);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=%b", req_ready, 4'b0000); end
      checks++; if (mux_sel !== 5'd0) begin errors++; $display("FAIL reset_mux_sel got=%0d exp=0", mux_sel); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
      checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got=%b exp=%b", req_ready, 4'b0001); end
    checks++; if (mux_sel !== 5'd1) begin errors++; $display("FAIL reset_first_sel got=%0d exp=1", mux_sel); end
    tick();
    req_valid = 4'b0000;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL reset_first_rsp got=%b/%0d exp=1/0", rsp_valid, rsp_id); end
    checks++; if (rsp_data !== 32'h1000_0001) begin errors++; $display("FAIL reset_first_data got=%h exp=%h", rsp_data, 32'h1000_0001); end
  endtask

  // rr_ptr is 1 on entry.
  task automatic test_single();
    set_addrs(5'd0, 5'd7, 5'd0, 5'd0);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=%b", req_ready, 4'b0100); end
    checks++; if (mux_sel !== 5'd7) begin errors++; $display("FAIL single_sel got=%0d exp=7", mux_sel); end
    tick();
    req_valid = 4'b0000;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp_id got=%0d exp=2", rsp_id); end
    checks++; if (rsp_data !== 32'h1000_0007) begin errors++; $display("FAIL single_rsp_data got=%h exp=%h", rsp_data, 32'h1000_0007); end
    #1;
    checks++; if (req_ready !== 4'b0000 || mux_sel !== 5'd0) begin errors++; $display("FAIL idle_ready got=%b sel=%0d exp=0000 sel=0", req_ready, mux_sel); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_id !== 2'd2 || rsp_data !== 32'h1000_0007) begin errors++; $display("FAIL idle_hold got=%0d/%h exp=2/%h", rsp_id, rsp_data, 32'h1000_0007); end
  endtask

  // rr_ptr is 3 on entry; a lone grant to 3 brings it back to 0 first.
  task automatic test_round_robin();
    logic [3:0]  exp_ready;
    logic [1:0]  exp_id;
    logic [31:0] exp_data;
    set_addrs(5'd13, 5'd12, 5'd11, 5'd10);
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rr_pre_ready got=%b exp=%b", req_ready, 4'b1000); end
    tick();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_id    = 2'(k % 4);
      exp_ready = 4'b0001 << exp_id;
      exp_data  = 32'h1000_000A + 32'(k % 4);
      #1;
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, exp_ready); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id) begin errors++; $display("FAIL rr_rsp[%0d] got=%b/%0d exp=1/%0d", k, rsp_valid, rsp_id, exp_id); end
      checks++; if (rsp_data !== exp_data) begin errors++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, rsp_data, exp_data); end
    end
    req_valid = 4'b0000;
  endtask

  // rr_ptr is 0 on entry; a lone grant to 2 moves it to 3.
  task automatic test_partial();
    logic [3:0] exp_seq [3];
    exp_seq[0] = 4'b0001;
    exp_seq[1] = 4'b0100;
    exp_seq[2] = 4'b0001;
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== exp_seq[k]) begin errors++; $display("FAIL partial_ready[%0d] got=%b exp=%b", k, req_ready, exp_seq[k]); end
      tick();
    end
    req_valid = 4'b0000;
  endtask

  // rr_ptr is 1 on entry.
  task automatic test_forward();
    set_addrs(5'd0, 5'd0, 5'd9, 5'd0);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hDEAD_BEEF;
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL fwd_ready got=%b exp=%b", req_ready, 4'b0010); end
    tick();
    checks++; if (rsp_data !== 32'hDEAD_BEEF || rsp_id !== 2'd1) begin errors++; $display("FAIL fwd_hit got=%h/%0d exp=%h/1", rsp_data, rsp_id, 32'hDEAD_BEEF); end
    wr_addr = 5'd10;
    tick();
    req_valid = 4'b0000;
    wr_en = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h1000_0009) begin errors++; $display("FAIL fwd_miss got=%b/%h exp=1/%h", rsp_valid, rsp_data, 32'h1000_0009); end
  endtask

  // rr_ptr is 2 on entry.
  task automatic test_zero_reset();
    set_addrs(5'd5, 5'd0, 5'd0, 5'd0);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001 || mux_sel !== 5'd0) begin errors++; $display("FAIL zero_grant got=%b sel=%0d exp=0001 sel=0", req_ready, mux_sel); end
    tick();
    wr_en = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin errors++; $display("FAIL zero_data got=%b/%h exp=1/0", rsp_valid, rsp_data); end
    req_valid = 4'b1000;
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_grant_ready got=%b exp=0000", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_grant_rsp got=%b exp=0", rsp_valid); end
    rst = 1'b0;
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_ptr got=%b exp=%b", req_ready, 4'b0001); end
    tick();
    req_valid = 4'b0000;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL rst_ptr_rsp got=%b/%0d exp=1/0", rsp_valid, rsp_id); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_partial();
    test_forward();
    test_zero_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
